// File: rtl/div_unit.sv
// div_unit: multi-cycle signed integer divider using a restoring shift-subtract loop.
// A start pulse in IDLE latches the operand magnitudes. RUN then resolves one
// quotient bit per cycle, and DONE posts a one-cycle result_rdy pulse.
// Optional feature macro: DIV_REMAINDER_EN adds a signed remainder output port.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] remainder
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_DIV0 = 2'd1,
    EXC_OVF  = 2'd2
  } exc_t;

  state_t           state;
  exc_t             exc_kind;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sign_q;

  logic [WIDTH-1:0] a_abs_c;
  logic [WIDTH-1:0] b_abs_c;
  logic [WIDTH:0]   shift_c;
  logic [WIDTH-1:0] diff_c;
  logic             fits_c;
  logic             accept_c;
  logic             div0_c;
  logic             ovf_c;

  // Operand magnitudes, the trial subtraction and the start qualifier.
  // rem is always below divisor (at most 2^(WIDTH-1)), so the W-bit register
  // never loses a bit. The W+1-bit shift path holds the bit shifted out for
  // the compare, and the difference always fits back into W bits.
  always_comb begin
    a_abs_c  = operandA[WIDTH-1] ? (-operandA) : operandA;
    b_abs_c  = operandB[WIDTH-1] ? (-operandB) : operandB;
    shift_c  = {rem, quo[WIDTH-1]};
    fits_c   = (shift_c >= {1'b0, divisor});
    diff_c   = shift_c[WIDTH-1:0] - divisor;
    accept_c = (state == S_IDLE) && !busy && ctrl_div;
    div0_c   = (operandB == '0);
    ovf_c    = (operandA == MIN_NEG) && (operandB == '1);
  end

  // Control FSM, datapath iteration and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      exc_kind   <= EXC_NONE;
      cnt        <= '0;
      divisor    <= '0;
      rem        <= '0;
      quo        <= '0;
      sign_q     <= 1'b0;
      result     <= '0;
      exception  <= 1'b0;
      result_rdy <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (busy) begin
            // Cycle following the result_rdy pulse: retire the op and ignore start.
            busy       <= 1'b0;
            result_rdy <= 1'b0;
          end else if (accept_c) begin
            busy    <= 1'b1;
            quo     <= a_abs_c;
            divisor <= b_abs_c;
            rem     <= '0;
            cnt     <= '0;
            sign_q  <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
            if (div0_c) begin
              exc_kind <= EXC_DIV0;
              state    <= S_DONE;
            end else if (ovf_c) begin
              exc_kind <= EXC_OVF;
              state    <= S_DONE;
            end else begin
              exc_kind <= EXC_NONE;
              state    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rem <= fits_c ? diff_c : shift_c[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fits_c};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          result_rdy <= 1'b1;
          state      <= S_IDLE;
          case (exc_kind)
            EXC_DIV0: begin
              result    <= '0;
              exception <= 1'b1;
            end
            EXC_OVF: begin
              result    <= MIN_NEG;
              exception <= 1'b1;
            end
            default: begin
              result    <= sign_q ? (-quo) : quo;
              exception <= 1'b0;
            end
          endcase
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DIV_REMAINDER_EN
  logic sign_r;

  // Remainder carries the dividend's sign and is zero for exceptional ops.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sign_r    <= 1'b0;
      remainder <= '0;
    end else begin
      if (accept_c) begin
        sign_r <= operandA[WIDTH-1];
      end
      if (state == S_DONE) begin
        if (exc_kind == EXC_NONE) begin
          remainder <= sign_r ? (-rem) : rem;
        end else begin
          remainder <= '0;
        end
      end
    end
  end
`else
  // Remainder output and its sign fix-up are not built; the quotient path is unchanged.
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit using hand-computed vectors.
module tb_div_unit;

  logic        clock;
  logic        resetn;
  logic        ctrl_div;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [31:0] result;
  logic        exception;
  logic        result_rdy;
  logic        busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] remainder;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.WIDTH(32)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .ctrl_div   (ctrl_div),
    .operandA   (operandA),
    .operandB   (operandB),
    .result     (result),
    .exception  (exception),
    .result_rdy (result_rdy),
    .busy       (busy)
`ifdef DIV_REMAINDER_EN
    ,
    .remainder  (remainder)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at the negedge following E0; returns the number of edges after E0 until result_rdy.
  task automatic wait_rdy(input int start_cnt, output int lat);
    lat = start_cnt;
    while (!result_rdy && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
  endtask

  // One complete operation with the expected quotient, exception, latency and remainder.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_q, input logic exp_e, input int exp_lat,
                       input logic [31:0] exp_r);
    int lat;
    @(negedge clock);
    operandA = a;
    operandB = b;
    ctrl_div = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_div = 1'b0;
    operandA = 32'h1234_5678;
    operandB = 32'h0000_0003;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    wait_rdy(0, lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, result, exp_q);
    check({tag, "_exception"}, 32'(exception), 32'(exp_e));
    check({tag, "_busy_rdy"}, 32'(busy), 32'd1);
`ifdef DIV_REMAINDER_EN
    check({tag, "_remainder"}, remainder, exp_r);
`else
    if (exp_r === 32'hxxxx_xxxx) $display("note: bad remainder vector for %s", tag);
`endif
    @(posedge clock);
    @(negedge clock);
    check({tag, "_rdy_drop"}, 32'(result_rdy), 32'd0);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int rdy_seen;
    resetn   = 1'b0;
    ctrl_div = 1'b0;
    operandA = '0;
    operandB = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_result", result, 32'd0);
    check("reset_exception", 32'(exception), 32'd0);
    check("reset_rdy", 32'(result_rdy), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Basic signed cases, exceptions and boundaries.
    do_op("pos_pos",  32'd100,       32'd7,         32'd14,        1'b0, 33, 32'd2);
    do_op("neg_pos",  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, 33, 32'hFFFF_FFFE);
    do_op("pos_neg",  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33, 32'd1);
    do_op("div0",     32'd5,         32'd0,         32'd0,         1'b1, 1,  32'd0);
    do_op("ovf",      32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1,  32'd0);
    do_op("min_by1",  32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 33, 32'd0);
    do_op("zero_num", 32'd0,         32'd5,         32'd0,         1'b0, 33, 32'd0);
    do_op("big",      32'h7FFF_FFFF, 32'h0000_0010, 32'h07FF_FFFF, 1'b0, 33, 32'd15);

    // Result holds while idle.
    repeat (3) @(negedge clock);
    check("hold_result", result, 32'h07FF_FFFF);
    check("hold_rdy", 32'(result_rdy), 32'd0);

    // Start during RUN is ignored.
    @(negedge clock);
    operandA = 32'd100;
    operandB = 32'd7;
    ctrl_div = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_div = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    operandA = 32'd9;
    operandB = 32'd3;
    ctrl_div = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_div = 1'b0;
    wait_rdy(10, lat);
    check("ignore_latency", 32'(lat), 32'd33);
    check("ignore_result", result, 32'd14);
    @(posedge clock);
    @(negedge clock);
    check("ignore_busy_drop", 32'(busy), 32'd0);

    // ctrl_div held high: second op starts on the first free IDLE edge.
    @(negedge clock);
    operandA = 32'd100;
    operandB = 32'd7;
    ctrl_div = 1'b1;
    @(posedge clock);
    @(negedge clock);
    operandA = 32'd9;
    operandB = 32'd3;
    wait_rdy(0, lat);
    check("b2b_first_latency", 32'(lat), 32'd33);
    check("b2b_first_result", result, 32'd14);
    @(posedge clock);
    @(negedge clock);
    check("b2b_gap_busy", 32'(busy), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("b2b_second_busy", 32'(busy), 32'd1);
    ctrl_div = 1'b0;
    wait_rdy(0, lat);
    check("b2b_second_latency", 32'(lat), 32'd33);
    check("b2b_second_result", result, 32'd3);
    @(posedge clock);
    @(negedge clock);

    // Asynchronous reset mid-operation aborts the op.
    @(negedge clock);
    operandA = 32'd100;
    operandB = 32'd7;
    ctrl_div = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_div = 1'b0;
    repeat (15) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdy", 32'(result_rdy), 32'd0);
    check("abort_exception", 32'(exception), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (result_rdy) rdy_seen++;
    end
    check("abort_no_rdy", 32'(rdy_seen), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    do_op("neg_neg", 32'hFFFF_FFF7, 32'hFFFF_FFFD, 32'd3, 1'b0, 33, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
